// File: rtl/cmos_pixel_packer.sv
// rtl/cmos_pixel_packer.sv - packs IN_W-bit sensor beats into IN_W*BEATS-bit pixels with frame/line markers
module cmos_pixel_packer #(
  parameter int IN_W        = 8,
  parameter int BEATS       = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int SKIP_FRAMES = 0,
  parameter int CNT_W       = 12
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vs_i,
  input  logic                  de_i,
  input  logic [IN_W-1:0]       pdata_i,
  output logic [IN_W*BEATS-1:0] pdata_o,
  output logic                  valid_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  line_err_o,
  output logic [CNT_W-1:0]      pix_cnt_o,
  output logic [CNT_W-1:0]      line_cnt_o
);
  localparam int OW = IN_W * BEATS;
  localparam int AW = OW - IN_W;
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [7:0] SKIP_N = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {IDLE, SKIP, RUN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       skip_q, skip_d;
  logic             vs_d, de_d;
  logic             fs, le;
  logic [BW-1:0]    bcnt;
  logic [AW-1:0]    acc;
  logic [OW-1:0]    word;
  logic [CNT_W-1:0] pix_cnt, line_cnt;
  logic             sof_pend;

  assign fs         = (vs_i == VS_POL) && (vs_d != VS_POL);
  assign le         = !de_i && de_d;
  assign line_cnt_o = line_cnt;

  // acc holds the first BEATS-1 beats; the word is completed with the live beat
  assign word = MSB_FIRST ? {acc, pdata_i} : {pdata_i, acc};

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      skip_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // skip_q counts frame starts seen, including the one that leaves IDLE
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    case (state_q)
      IDLE: if (fs) begin
        skip_d  = 8'd1;
        state_d = (SKIP_FRAMES > 0) ? SKIP : RUN;
      end
      SKIP: if (fs) begin
        if (skip_q >= SKIP_N) state_d = RUN;
        else                  skip_d  = skip_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_d       <= VS_POL;
      de_d       <= 1'b0;
      bcnt       <= '0;
      acc        <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      sof_pend   <= 1'b0;
      pdata_o    <= '0;
      valid_o    <= 1'b0;
      sof_o      <= 1'b0;
      eol_o      <= 1'b0;
      line_err_o <= 1'b0;
      pix_cnt_o  <= '0;
    end else begin
      vs_d       <= vs_i;
      de_d       <= de_i;
      valid_o    <= 1'b0;
      sof_o      <= 1'b0;
      eol_o      <= 1'b0;
      line_err_o <= 1'b0;
      if (fs) begin
        bcnt     <= '0;
        pix_cnt  <= '0;
        line_cnt <= '0;
        sof_pend <= 1'b1;
      end else if (state_q == RUN) begin
        if (de_i) begin
          if (bcnt == LAST_BEAT) begin
            bcnt      <= '0;
            pdata_o   <= word;
            valid_o   <= 1'b1;
            sof_o     <= sof_pend;
            sof_pend  <= 1'b0;
            pix_cnt_o <= pix_cnt;
            pix_cnt   <= (&pix_cnt) ? pix_cnt : pix_cnt + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
            acc  <= MSB_FIRST ? AW'(word) : AW'(word >> IN_W);
          end
        end else begin
          bcnt <= '0;
          if (le) begin
            eol_o      <= 1'b1;
            line_err_o <= (bcnt != '0);
            line_cnt   <= (&line_cnt) ? line_cnt : line_cnt + 1'b1;
            pix_cnt    <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// tb/tb_cmos_pixel_packer.sv - scoreboard bench for cmos_pixel_packer over four parameter sets
module tb_cmos_pixel_packer;
  logic       pclk;
  logic [3:0] rst;
  logic       vs_i, de_i;
  logic [7:0] pdata_i;

  logic [15:0] pd0, pd2, pd3;
  logic [23:0] pd1;
  logic [3:0]  v, sof, eol, err;
  logic [11:0] pc0, lc0, pc1, lc1, pc2, lc2;
  logic [1:0]  pc3, lc3;

  logic [23:0] pdw [4];
  logic [11:0] pcw [4];
  logic [11:0] lcw [4];

  int tests = 0;
  int fails = 0;

  typedef struct { int id; int pd; int pix; int line; int sof; } pix_t;
  typedef struct { int id; int err; } eol_t;
  pix_t pix_q[$];
  eol_t eol_q[$];

  cmos_pixel_packer d0 (.pclk(pclk), .rst(rst[0]), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
    .pdata_o(pd0), .valid_o(v[0]), .sof_o(sof[0]), .eol_o(eol[0]), .line_err_o(err[0]),
    .pix_cnt_o(pc0), .line_cnt_o(lc0));
  cmos_pixel_packer #(.IN_W(8), .BEATS(3), .MSB_FIRST(1'b0)) d1 (.pclk(pclk), .rst(rst[1]),
    .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i), .pdata_o(pd1), .valid_o(v[1]), .sof_o(sof[1]),
    .eol_o(eol[1]), .line_err_o(err[1]), .pix_cnt_o(pc1), .line_cnt_o(lc1));
  cmos_pixel_packer #(.SKIP_FRAMES(2)) d2 (.pclk(pclk), .rst(rst[2]), .vs_i(vs_i), .de_i(de_i),
    .pdata_i(pdata_i), .pdata_o(pd2), .valid_o(v[2]), .sof_o(sof[2]), .eol_o(eol[2]),
    .line_err_o(err[2]), .pix_cnt_o(pc2), .line_cnt_o(lc2));
  cmos_pixel_packer #(.CNT_W(2)) d3 (.pclk(pclk), .rst(rst[3]), .vs_i(vs_i), .de_i(de_i),
    .pdata_i(pdata_i), .pdata_o(pd3), .valid_o(v[3]), .sof_o(sof[3]), .eol_o(eol[3]),
    .line_err_o(err[3]), .pix_cnt_o(pc3), .line_cnt_o(lc3));

  assign pdw[0] = {8'h00, pd0};
  assign pdw[1] = pd1;
  assign pdw[2] = {8'h00, pd2};
  assign pdw[3] = {8'h00, pd3};
  assign pcw[0] = pc0;
  assign pcw[1] = pc1;
  assign pcw[2] = pc2;
  assign pcw[3] = {10'd0, pc3};
  assign lcw[0] = lc0;
  assign lcw[1] = lc1;
  assign lcw[2] = lc2;
  assign lcw[3] = {10'd0, lc3};

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got 1, expected 0", name);
  endtask

  task automatic check_pix(input int i);
    pix_t e;
    if (pix_q.size() == 0) begin
      flag($sformatf("unexpected_pixel_d%0d", i));
    end else begin
      e = pix_q.pop_front();
      chk("pix_instance", i, e.id);
      chk("pdata_o", pdw[i], e.pd);
      chk("pix_cnt_o", pcw[i], e.pix);
      chk("line_cnt_o_at_pixel", lcw[i], e.line);
      chk("sof_o", sof[i], e.sof);
    end
  endtask

  task automatic check_eol(input int i);
    eol_t e;
    if (eol_q.size() == 0) begin
      flag($sformatf("unexpected_eol_d%0d", i));
    end else begin
      e = eol_q.pop_front();
      chk("eol_instance", i, e.id);
      chk("line_err_o", err[i], e.err);
    end
  endtask

  always @(negedge pclk) begin
    for (int i = 0; i < 4; i++) begin
      if (v[i]) check_pix(i);
      if (eol[i]) check_eol(i);
      if (v[i] && eol[i]) flag("valid_and_eol_together");
      if (err[i] && !eol[i]) flag("line_err_without_eol");
      if (sof[i] && !v[i]) flag("sof_without_valid");
    end
  end

  task automatic step(input logic vs, input logic de, input logic [7:0] d);
    vs_i = vs;
    de_i = de;
    pdata_i = d;
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset(input int id, input logic vs);
    rst = 4'hF;
    repeat (2) step(vs, 1'b0, 8'h00);
    rst = 4'hF & ~(4'b0001 << id);
    step(vs, 1'b0, 8'h00);
  endtask

  task automatic exp_pix(input int id, input int pd, input int pix, input int line, input int s);
    pix_t e;
    e.id = id; e.pd = pd; e.pix = pix; e.line = line; e.sof = s;
    pix_q.push_back(e);
  endtask

  task automatic exp_eol(input int id, input int e_err);
    eol_t e;
    e.id = id; e.err = e_err;
    eol_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 4'hF; vs_i = 1'b0; de_i = 1'b0; pdata_i = 8'h00;

    // reset state of the default instance
    do_reset(0, 1'b0);
    chk("reset_pdata_o", pd0, 0);
    chk("reset_valid_o", v[0], 0);
    chk("reset_sof_o", sof[0], 0);
    chk("reset_eol_o", eol[0], 0);
    chk("reset_line_err_o", err[0], 0);
    chk("reset_pix_cnt_o", pc0, 0);
    chk("reset_line_cnt_o", lc0, 0);

    // one 8-beat line, MSB first
    exp_pix(0, 'h1122, 0, 0, 1);
    exp_pix(0, 'h3344, 1, 0, 0);
    exp_pix(0, 'h5566, 2, 0, 0);
    exp_pix(0, 'h7788, 3, 0, 0);
    exp_eol(0, 0);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 8'(8'h11 * i));
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("line_cnt_after_line0", lc0, 1);

    // odd line of 5 beats, then a clean 2-beat line
    exp_pix(0, 'hA0A1, 0, 1, 0);
    exp_pix(0, 'hA2A3, 1, 1, 0);
    exp_eol(0, 1);
    exp_pix(0, 'hB0B1, 0, 2, 0);
    exp_eol(0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'hA0 + i));
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hB0);
    step(1'b1, 1'b1, 8'hB1);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("line_cnt_after_odd_line", lc0, 3);

    // vsync held active through reset: no frame start until a fresh edge
    do_reset(0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 8'(i));
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    exp_pix(0, 'hC1C2, 0, 0, 1);
    exp_eol(0, 0);
    exp_pix(0, 'hD3D4, 0, 0, 1);
    exp_eol(0, 0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hC1);
    step(1'b1, 1'b1, 8'hC2);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hD1);
    step(1'b1, 1'b1, 8'hD2);
    chk("line_cnt_after_midline_fs", lc0, 0);
    step(1'b1, 1'b1, 8'hD3);
    step(1'b1, 1'b1, 8'hD4);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // LSB first, three beats per pixel
    do_reset(1, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    exp_pix(1, 'hC3B2A1, 0, 0, 1);
    exp_eol(1, 0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hA1);
    step(1'b1, 1'b1, 8'hB2);
    step(1'b1, 1'b1, 8'hC3);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // two settle frames skipped, third frame packed
    do_reset(2, 1'b1);
    for (int f = 1; f <= 3; f++) begin
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      if (f == 3) begin
        exp_pix(2, 'h3132, 0, 0, 1);
        exp_pix(2, 'h3334, 1, 0, 0);
        exp_eol(2, 0);
      end
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, 8'(16 * f + k));
      step(1'b1, 1'b0, 8'h00);
    end
    step(1'b1, 1'b0, 8'h00);

    // 2-bit counters saturate
    do_reset(3, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    exp_pix(3, 'h0102, 0, 0, 1);
    exp_pix(3, 'h0304, 1, 0, 0);
    exp_pix(3, 'h0506, 2, 0, 0);
    exp_pix(3, 'h0708, 3, 0, 0);
    exp_pix(3, 'h090A, 3, 0, 0);
    exp_pix(3, 'h0B0C, 3, 0, 0);
    exp_eol(3, 0);
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, 8'(i));
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("line_cnt_cnt2", lc3, 1);

    repeat (3) step(1'b1, 1'b0, 8'h00);
    chk("pixels_outstanding", pix_q.size(), 0);
    chk("eols_outstanding", eol_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
